// File: rtl/uart_rx_frame_if.sv
// Serial receive interface: line and frame configuration toward the receiver,
// received word and per-frame status pulses back from it.
interface uart_rx_frame_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                  RX_IN;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [5:0]            PRESCALE;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_ERR;
   logic                  STP_ERR;

   // Line driver side (serial source / configuration owner)
   modport master (
      output RX_IN, PAR_EN, PAR_TYP, PRESCALE,
      input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
   );

   // Receiver side
   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP, PRESCALE,
      output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
   );
endinterface

// File: rtl/uart_rx_frame.sv
// UART frame receiver: oversampled start/data/parity/stop decoding with a
// 2-of-3 majority vote around mid-bit, one-cycle result pulses.
module uart_rx_frame #(
   parameter int DATA_WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   uart_rx_frame_if.slave   rx_if
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state;
   logic [5:0]            edge_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [2:0]            samp;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  par_en_r;
   logic                  par_typ_r;
   logic                  par_err_r;
   logic [DATA_WIDTH-1:0] p_data_r;
   logic                  data_valid_r;
   logic                  par_err_p;
   logic                  stp_err_p;

   logic [5:0]            half;
   logic                  bit_end;
   logic                  in_window;
   logic                  vote;
   logic [DATA_WIDTH:0]   shift_in;

   // Bit timing: last edge of a bit period, and the three mid-bit vote edges
   always_comb begin
      half      = rx_if.PRESCALE >> 1;
      bit_end   = (edge_cnt == rx_if.PRESCALE - 6'd1);
      in_window = (edge_cnt == half - 6'd1) || (edge_cnt == half) ||
                  (edge_cnt == half + 6'd1);
      vote      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
      // New bit enters at the MSB so the first data bit ends up at bit 0
      shift_in  = {vote, shreg};
   end

   // Receive FSM with edge/bit counters, vote samples and registered results
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         edge_cnt     <= '0;
         bit_cnt      <= '0;
         samp         <= '0;
         shreg        <= '0;
         par_en_r     <= 1'b0;
         par_typ_r    <= 1'b0;
         par_err_r    <= 1'b0;
         p_data_r     <= '0;
         data_valid_r <= 1'b0;
         par_err_p    <= 1'b0;
         stp_err_p    <= 1'b0;
      end else begin
         data_valid_r <= 1'b0;
         par_err_p    <= 1'b0;
         stp_err_p    <= 1'b0;

         // Only the three window edges feed the vote; anything else on the line is ignored
         if (state != IDLE && in_window)
            samp <= {samp[1:0], rx_if.RX_IN};

         if (state != IDLE)
            edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;

         case (state)
            IDLE: begin
               // Frame configuration is captured here and frozen for the whole frame
               par_en_r  <= rx_if.PAR_EN;
               par_typ_r <= rx_if.PAR_TYP;
               par_err_r <= 1'b0;
               bit_cnt   <= '0;
               edge_cnt  <= 6'd0;
               if (!rx_if.RX_IN) begin
                  // This cycle is edge 0 of the start bit
                  state    <= START;
                  edge_cnt <= 6'd1;
               end
            end

            START: begin
               if (bit_end)
                  state <= vote ? IDLE : DATA;
            end

            DATA: begin
               if (bit_end) begin
                  shreg   <= shift_in[DATA_WIDTH:1];
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT)
                     state <= par_en_r ? PARITY : STOP;
               end
            end

            PARITY: begin
               if (bit_end) begin
                  par_err_r <= vote != ((^shreg) ^ par_typ_r);
                  state     <= STOP;
               end
            end

            STOP: begin
               if (bit_end) begin
                  state <= IDLE;
                  if (!par_err_r && vote) begin
                     p_data_r     <= shreg;
                     data_valid_r <= 1'b1;
                  end else begin
                     par_err_p <= par_err_r;
                     stp_err_p <= !vote;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign rx_if.P_DATA     = p_data_r;
   assign rx_if.DATA_VALID = data_valid_r;
   assign rx_if.PAR_ERR    = par_err_p;
   assign rx_if.STP_ERR    = stp_err_p;

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 CLK  input  1  oversampling clock; all logic on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 RX_IN  input  1  serial line, idle high; already synchronous to CLK (synchronizer external).
REQ-005 PAR_EN  input  1  1 = parity bit present between data and stop.
REQ-006 PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-007 PRESCALE  input  6  CLK cycles per bit; legal values 8, 16, 32 only; other values undefined, bench shall not drive them.
REQ-008 P_DATA  output  DATA_WIDTH  last correctly received data word, LSB = first data bit.
REQ-009 DATA_VALID  output  1  one-cycle pulse, P_DATA newly updated.
REQ-010 PAR_ERR  output  1  one-cycle pulse, parity mismatch in frame just ended.
REQ-011 STP_ERR  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-012 Frame: start (0), DATA_WIDTH data bits LSB first, optional parity, one stop (1).
REQ-013 FSM states IDLE, START, DATA, PARITY, STOP; PAR_EN and PAR_TYP sampled only in IDLE and held for the frame.
REQ-014 Per-bit edge counter runs 0..PRESCALE-1; the IDLE cycle in which RX_IN is first low is edge 0 of the start bit.
REQ-015 Bit value = 2-of-3 majority of RX_IN at edges PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1.
REQ-016 IDLE -> START when RX_IN = 0; otherwise remain in IDLE.
REQ-017 START: at edge PRESCALE-1, voted 0 -> DATA; voted 1 (glitch) -> IDLE, no output pulses.
REQ-018 DATA: shift voted bit into data register each bit; after bit DATA_WIDTH-1 at edge PRESCALE-1 -> PARITY if PAR_EN else STOP.
REQ-019 PARITY: expected = XOR of data bits, inverted when PAR_TYP = 1; mismatch recorded; at edge PRESCALE-1 -> STOP.
REQ-020 STOP: at edge PRESCALE-1 -> IDLE and frame result registered; outputs change the following cycle.
REQ-021 Result: no parity error and stop = 1 -> P_DATA loaded, DATA_VALID = 1 for exactly one cycle.
REQ-022 Any error -> DATA_VALID stays 0, P_DATA holds its previous value, PAR_ERR and/or STP_ERR pulse one cycle; both may pulse together.
REQ-023 Latency: outputs valid one CLK after the last cycle of the stop bit period.
REQ-024 Back-to-back frames: RX_IN low in the first IDLE cycle after STOP starts a new frame with no lost cycle.
REQ-025 RX_IN activity during DATA/PARITY/STOP outside the vote window is ignored.

Reset
REQ-026 RST = 1 at a rising edge: FSM -> IDLE, counters 0, P_DATA = 0, DATA_VALID = 0, PAR_ERR = 0, STP_ERR = 0.
REQ-027 Reset mid-frame aborts the frame with no output pulse; reception resumes on the next start edge after RST = 0.
REQ-028 All state is updated on CLK only; no asynchronous reset path.

Verification
REQ-029 PRESCALE=8, PAR_EN=0, send 0xA5 -> DATA_VALID one cycle, P_DATA=0xA5, 80 cycles from start edge plus 1.
REQ-030 PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> P_DATA=0x3C, DATA_VALID=1; with parity 1 -> PAR_ERR pulse, P_DATA unchanged.
REQ-031 PRESCALE=32, PAR_TYP=1, 0x01 with stop=0 -> STP_ERR pulse, DATA_VALID=0.
REQ-032 Start glitch low for 3 cycles at PRESCALE=16 -> FSM returns to IDLE, no outputs; following valid 0x55 frame received correctly.
REQ-033 Single-cycle glitch on edge PRESCALE/2 of data bit 2 in 0x00 frame -> majority vote gives P_DATA=0x00.
REQ-034 RST asserted mid-DATA of 0xFF then frames 0x12, 0x34 back-to-back -> no pulse for aborted frame, two DATA_VALID pulses with 0x12 then 0x34.
